ffn_layer_mac: RTL and testbench
================================

FFN_LAYER_MAC -- requirements
Module: ffn_layer_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning signed input neuron / weight width (two's complement).
REQ-002 SHALL have parameter N_IN, default 4, meaning input neuron count (>=2).
REQ-003 SHALL have parameter N_OUT, default 4, meaning output neuron count, one MAC lane each.
REQ-004 SHALL have parameter SATURATE, default 1, meaning 1 = clamp outputs, 0 = wrap (truncate).
REQ-005 SHALL derive localparams OUT_W = 2*DATA_W, ACC_W = 2*DATA_W + clog2(N_IN), WA_W = clog2(N_IN*N_OUT).
REQ-006 SHALL have port clock  input  1  sole clock, all logic rising-edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  input vector valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a vector.
REQ-010 SHALL have port input_neurons  input  DATA_W*N_IN  packed vector, neuron i at bits [DATA_W*i +: DATA_W].
REQ-011 SHALL have port w_we  input  1  weight write strobe.
REQ-012 SHALL have port w_addr  input  WA_W  weight index = i*N_OUT + j.
REQ-013 SHALL have port w_data  input  DATA_W  signed weight W[i][j].
REQ-014 SHALL have port w_err  output  1  one-cycle pulse: write dropped.
REQ-015 SHALL have port out_valid  output  1  result vector valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts result.
REQ-017 SHALL have port output_neurons  output  OUT_W*N_OUT  packed result, neuron j at [OUT_W*j +: OUT_W].

Function
REQ-018 SHALL implement states IDLE, MAC, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-019 SHALL, in IDLE on in_valid&&in_ready, register input_neurons, clear all accumulators, set counter k=0, enter MAC.
REQ-020 SHALL, each MAC cycle, perform acc[j] += x[k]*W[k][j] for all j in parallel, signed, ACC_W bits (no internal overflow possible).
REQ-021 SHALL advance k each MAC cycle and enter DONE after the cycle with k==N_IN-1.
REQ-022 SHALL assert out_valid exactly N_IN+1 cycles after the accepting edge (default: 5).
REQ-023 SHALL, with SATURATE=1, clamp each acc to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; with SATURATE=0 output acc[OUT_W-1:0].
REQ-024 SHALL hold output_neurons and out_valid stable in DONE until out_ready; on out_valid&&out_ready return to IDLE (in_ready high next cycle).
REQ-025 SHALL ignore in_valid outside IDLE (no buffering, no overlap).
REQ-026 SHALL store weights in an internal N_IN*N_OUT register file; w_we accepted only in IDLE, write visible from next cycle.
REQ-027 SHALL drop w_we outside IDLE and pulse w_err for one cycle; w_we in IDLE coincident with an accepted vector SHALL be written and the new value used for the vector.
REQ-028 SHALL ignore w_addr >= N_IN*N_OUT and pulse w_err.
REQ-029 SHALL drive output_neurons to zero whenever not in DONE.

Reset
REQ-030 SHALL, on reset, force state IDLE, k=0, accumulators, captured vector and all weights to zero, w_err=0, out_valid=0, in_ready=1 the following cycle.
REQ-031 SHALL honour reset in any state, including mid-MAC and DONE, discarding the in-flight vector.

Structure
REQ-032 SHALL take DATA_W, N_IN, N_OUT defaults from the shared header network_params.h (FFN_WIDTH, NUM_INPUT_N, NUM_OUTPUT_N), plus state encoding and clog2 helper there.
REQ-033 SHALL instantiate N_OUT copies of one sub-module mac_lane (signed multiply, accumulate, clear, saturate/wrap output).

Verification
REQ-034 SHALL cover identity: W[i][j]=(i==j), x=(1,-2,3,-4) -> output (1,-2,3,-4), out_valid 5 cycles after handshake.
REQ-035 SHALL cover saturation: all x=-128, all W=-128 -> each acc 65536; SATURATE=1 gives 32767, SATURATE=0 gives 0.
REQ-036 SHALL cover backpressure: out_ready low 10 cycles in DONE -> out_valid and data stable, in_ready=0, in_valid pulses ignored.
REQ-037 SHALL cover write while busy: w_we during MAC -> w_err one-cycle pulse, result uses old weights, later read-back via identity run unchanged.
REQ-038 SHALL cover reset at k=2 -> next cycle IDLE, in_ready=1, out_valid=0; following vector x=(5,5,5,5) yields all-zero outputs.

Source files
------------

// File: rtl/ffn_layer_mac_pkg.sv
// Shared network parameters for the feed-forward MAC layer: default
// layer dimensions, controller state encoding and a constant clog2 helper.
package ffn_layer_mac_pkg;

  // Default layer geometry
  localparam int FFN_WIDTH    = 8;
  localparam int NUM_INPUT_N  = 4;
  localparam int NUM_OUTPUT_N = 4;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2, usable in parameter elaboration
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ffn_layer_mac_lane.sv
// One output-neuron MAC lane: signed multiply of registered operands,
// wide accumulation, and a clamped or wrapped result.
module mac_lane #(
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 16,
  parameter int ACC_W    = 18,
  parameter int SATURATE = 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_acc_en,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_w,
  output logic signed [OUT_W-1:0]  o_result
);

  // Clamp bounds expressed at accumulator width so the compare is exact
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [OUT_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod     = i_x * i_w;
  assign w_prod_ext = {{(ACC_W-OUT_W){w_prod[OUT_W-1]}}, w_prod};

  // Accumulator: cleared when a new vector is accepted, summed on enable
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  // Output stage: clamp to the output range or keep the low bits
  always_comb begin
    o_result = r_acc[OUT_W-1:0];
    if (SATURATE != 0) begin
      if (r_acc > SAT_MAX) begin
        o_result = SAT_MAX[OUT_W-1:0];
      end else if (r_acc < SAT_MIN) begin
        o_result = SAT_MIN[OUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ffn_layer_mac.sv
// Fully-connected layer MAC: accepts one input vector, walks the input
// neurons one per cycle through N_OUT parallel lanes, then holds the
// result until downstream takes it. Weight row and input term are
// registered one cycle ahead of the accumulate, giving a fixed
// N_IN+1 cycle latency from acceptance to out_valid.
module ffn_layer_mac
  import ffn_layer_mac_pkg::*;
#(
  parameter  int DATA_W   = FFN_WIDTH,
  parameter  int N_IN     = NUM_INPUT_N,
  parameter  int N_OUT    = NUM_OUTPUT_N,
  parameter  int SATURATE = 1,
  localparam int OUT_W    = 2*DATA_W,
  localparam int ACC_W    = 2*DATA_W + clog2(N_IN),
  localparam int WA_W     = clog2(N_IN*N_OUT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W*N_IN-1:0]  input_neurons,
  input  logic                    w_we,
  input  logic [WA_W-1:0]         w_addr,
  input  logic [DATA_W-1:0]       w_data,
  output logic                    w_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W*N_OUT-1:0]  output_neurons
);

  localparam int        KW     = clog2(N_IN);
  localparam int        N_W    = N_IN*N_OUT;
  localparam logic [KW-1:0] K_LAST = KW'(N_IN-1);

  logic [1:0]               r_state;
  logic [KW-1:0]            r_k;
  logic                     r_fetch_on;
  logic                     r_acc_en;
  logic                     r_last;
  logic                     r_w_err;
  logic signed [DATA_W-1:0] r_x    [N_IN];
  logic signed [DATA_W-1:0] r_w    [N_W];
  logic signed [DATA_W-1:0] r_wrow [N_OUT];
  logic signed [DATA_W-1:0] r_xk;

  logic                     w_idle;
  logic                     w_accept;
  logic                     w_addr_ok;
  logic                     w_wr;
  logic signed [OUT_W-1:0]  w_lane_out [N_OUT];

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle && in_valid;
  assign w_addr_ok = (32'(w_addr) < N_W);
  assign w_wr      = w_we && w_idle && w_addr_ok;

  assign in_ready  = w_idle;
  assign out_valid = (r_state == ST_DONE);
  assign w_err     = r_w_err;

  // Controller, weight file, input capture and per-step operand fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_fetch_on <= 1'b0;
      r_acc_en   <= 1'b0;
      r_last     <= 1'b0;
      r_w_err    <= 1'b0;
      r_xk       <= '0;
      for (int i = 0; i < N_IN; i++)  r_x[i]    <= '0;
      for (int i = 0; i < N_W; i++)   r_w[i]    <= '0;
      for (int j = 0; j < N_OUT; j++) r_wrow[j] <= '0;
    end else begin
      // A write is dropped (and flagged) when busy or out of range
      r_w_err <= w_we && !w_wr;
      if (w_wr) begin
        r_w[w_addr] <= w_data;
      end

      case (r_state)
        ST_IDLE: begin
          r_acc_en <= 1'b0;
          if (in_valid) begin
            for (int i = 0; i < N_IN; i++) begin
              r_x[i] <= input_neurons[DATA_W*i +: DATA_W];
            end
            r_k        <= '0;
            r_fetch_on <= 1'b1;
            r_last     <= 1'b0;
            r_state    <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc_en <= r_fetch_on;
          if (r_fetch_on) begin
            r_xk <= r_x[r_k];
            for (int j = 0; j < N_OUT; j++) begin
              r_wrow[j] <= r_w[WA_W'(int'(r_k) * N_OUT + j)];
            end
            r_last <= (r_k == K_LAST);
            if (r_k == K_LAST) begin
              r_fetch_on <= 1'b0;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
          // Leave once the last input term has been accumulated
          if (r_acc_en && r_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_acc_en <= 1'b0;
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_acc_en <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_lane
      mac_lane #(
        .DATA_W   (DATA_W),
        .OUT_W    (OUT_W),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
      ) u_lane (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_clear  (w_accept),
        .i_acc_en (r_acc_en),
        .i_x      (r_xk),
        .i_w      (r_wrow[gi]),
        .o_result (w_lane_out[gi])
      );
      assign output_neurons[OUT_W*gi +: OUT_W] = out_valid ? w_lane_out[gi] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_ffn_layer_mac.sv
// Scoreboard bench for ffn_layer_mac: two instances (clamping and
// wrapping) share stimulus; expected vectors are queued at issue and
// checked by a monitor at each output handshake.
module tb_ffn_layer_mac;

  localparam int DATA_W = 8;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 4;
  localparam int OUT_W  = 16;
  localparam int WA_W   = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic w_we = 1'b0;
  logic out_ready = 1'b1;
  logic [DATA_W*N_IN-1:0] input_neurons = '0;
  logic [WA_W-1:0]        w_addr = '0;
  logic [DATA_W-1:0]      w_data = '0;
  logic in_ready_s, w_err_s, out_valid_s;
  logic in_ready_w, w_err_w, out_valid_w;
  logic [OUT_W*N_OUT-1:0] out_s, out_w;

  typedef struct {
    logic [63:0] exp_sat;
    logic [63:0] exp_wrap;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int txn = 0;

  ffn_layer_mac #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .input_neurons(input_neurons), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .w_err(w_err_s), .out_valid(out_valid_s), .out_ready(out_ready), .output_neurons(out_s));

  ffn_layer_mac #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .input_neurons(input_neurons), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .w_err(w_err_w), .out_valid(out_valid_w), .out_ready(out_ready), .output_neurons(out_w));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] px(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [63:0] py(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // All tasks start and end at posedge+1
  task automatic write_w(input int addr, input int data);
    w_we = 1'b1; w_addr = WA_W'(addr); w_data = DATA_W'(data);
    @(posedge clock); #1;
    w_we = 1'b0;
  endtask

  task automatic load_identity();
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++)
        write_w(i*N_OUT + j, (i == j) ? 1 : 0);
  endtask

  task automatic load_fill(input int v);
    for (int a = 0; a < N_IN*N_OUT; a++) write_w(a, v);
  endtask

  task automatic send(input logic [31:0] x, input logic [63:0] es, input logic [63:0] ew,
                      input bit do_w = 1'b0, input int wa = 0, input int wd = 0);
    exp_t e;
    in_valid = 1'b1; input_neurons = x;
    if (do_w) begin w_we = 1'b1; w_addr = WA_W'(wa); w_data = DATA_W'(wd); end
    @(negedge clock);
    check("in_ready_at_send", 64'(in_ready_s), 64'd1);
    e.exp_sat = es; e.exp_wrap = ew; e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clock); #1;
    in_valid = 1'b0; w_we = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready_s) && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
    check({name, "_idle"}, 64'(in_ready_s), 64'd1);
  endtask

  // Monitor: latency on first out_valid, data on each handshake
  initial begin
    exp_t e;
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        seen = 1'b0;
      end else if (out_valid_s) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid_s), 64'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check("latency", 64'(cyc - sb[0].acc_cyc), 64'd5);
          end
          if (out_ready) begin
            e = sb.pop_front();
            check("out_sat", out_s, e.exp_sat);
            check("out_wrap", out_w, e.exp_wrap);
            check("out_valid_wrap", 64'(out_valid_w), 64'd1);
            seen = 1'b0;
            txn++;
            $display("txn %0d: sat=%h wrap=%h", txn, out_s, out_w);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready_s), 64'd1);
    check("rst_in_ready_wrap", 64'(in_ready_w), 64'd1);
    check("rst_out_valid", 64'(out_valid_s), 64'd0);
    check("rst_w_err", 64'(w_err_s), 64'd0);
    check("rst_outputs", out_s, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Identity weights
    load_identity();
    send(px(1, -2, 3, -4), py(1, -2, 3, -4), py(1, -2, 3, -4));
    wait_done("identity");

    // Write coincident with acceptance is used by that vector: W[3][0]=2
    send(px(1, -2, 3, -4), py(-7, -2, 3, -4), py(-7, -2, 3, -4), 1'b1, 12, 2);
    wait_done("coincident_write");

    // Positive overflow: 4 * 16384 = 65536
    load_fill(-128);
    send(px(-128, -128, -128, -128), py(32767, 32767, 32767, 32767), py(0, 0, 0, 0));
    wait_done("sat_pos");

    // Negative overflow: 4 * -16256 = -65024, wraps to 512
    load_fill(127);
    send(px(-128, -128, -128, -128), py(-32768, -32768, -32768, -32768), py(512, 512, 512, 512));
    wait_done("sat_neg");

    // Backpressure: hold DONE for 10 cycles, in_valid pulses ignored
    load_identity();
    out_ready = 1'b0;
    send(px(100, -100, 127, -128), py(100, -100, 127, -128), py(100, -100, 127, -128));
    for (int n = 0; n < 20 && !out_valid_s; n++) begin
      @(posedge clock); #1;
    end
    check("bp_reached_done", 64'(out_valid_s), 64'd1);
    for (int n = 0; n < 10; n++) begin
      in_valid = n[0];
      input_neurons = px(9, 9, 9, 9);
      @(negedge clock);
      check("bp_out_valid", 64'(out_valid_s), 64'd1);
      check("bp_data", out_s, py(100, -100, 127, -128));
      check("bp_in_ready", 64'(in_ready_s), 64'd0);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done("backpressure");

    // Write while busy is dropped and flagged for one cycle
    send(px(10, 20, 30, 40), py(10, 20, 30, 40), py(10, 20, 30, 40));
    w_we = 1'b1; w_addr = '0; w_data = 8'd7;
    @(posedge clock); #1;
    w_we = 1'b0;
    @(negedge clock);
    check("busy_w_err", 64'(w_err_s), 64'd1);
    check("busy_w_err_wrap", 64'(w_err_w), 64'd1);
    @(negedge clock);
    check("busy_w_err_clear", 64'(w_err_s), 64'd0);
    wait_done("busy_write");
    send(px(1, -2, 3, -4), py(1, -2, 3, -4), py(1, -2, 3, -4));
    wait_done("readback");

    // Reset mid-MAC at k=2 discards the vector and clears the weights
    in_valid = 1'b1; input_neurons = px(1, 1, 1, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_in_ready", 64'(in_ready_s), 64'd1);
    check("midrst_out_valid", 64'(out_valid_s), 64'd0);
    check("midrst_outputs", out_s, 64'd0);
    @(posedge clock); #1;
    send(px(5, 5, 5, 5), py(0, 0, 0, 0), py(0, 0, 0, 0));
    wait_done("after_reset");

    repeat (5) @(posedge clock);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
